instr_prefetch: RTL

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch.sv | 87 ++++++++
 1 files changed

// File: rtl/instr_prefetch.sv
// Instruction prefetch unit: issues single-outstanding ROM reads ahead of decode and
// buffers returned words in a small FIFO, flushing on branch/jump redirects.
module instr_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        rom_rd_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic             deq;
    logic             enq;
    logic [CNT_W:0]   occupancy;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign instr_valid = (count != '0) && !redirect_valid;
    assign instr_data  = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign deq         = instr_valid && instr_ready;
    // A word returning in a redirect cycle belongs to the abandoned path.
    assign enq         = inflight && !redirect_valid;

    // Reserving a slot for the outstanding read keeps the FIFO from ever overflowing.
    assign occupancy   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(deq);
    assign rom_rd_en   = reset_n && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
    assign rom_addr    = fetch_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= rom_rd_en;
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (rom_rd_en) fetch_pc <= fetch_pc + 32'd4;
                if (enq) wr_ptr <= next_ptr(wr_ptr);
                if (deq) rd_ptr <= next_ptr(rd_ptr);
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rom_rd_en) inflight_pc <= fetch_pc;
        if (enq) begin
            pc_mem[wr_ptr]   <= inflight_pc;
            data_mem[wr_ptr] <= rom_rdata;
        end
    end

endmodule
